// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
package uart_rx_pkg;

  // Ticks per bit period and the tick count at which a bit is sampled.
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;
  localparam int unsigned CNT_W      = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

endpackage

// File: rtl/oversample_counter.sv
// Mod-OVERSAMPLE tick counter used to locate the middle of each bit period.
module oversample_counter
  import uart_rx_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  // Clear wins over enable; the counter wraps naturally at OVERSAMPLE.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/uart_rx_controller.sv
// 16x oversampled UART receiver: synchronizer, framing FSM and shift register.
module uart_rx_controller
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_tick,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       char_valid,
  output logic       framing_error,
  output logic       busy
);

  localparam logic [2:0] IdxLast = 3'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]           data_q, data_d;
  logic                 cv_q, cv_d;
  logic                 fe_q, fe_d;
  logic                 rx_meta, rx_sync;
  logic                 cnt_clear, cnt_en;
  logic [CNT_W-1:0]     count;
  logic                 sample_pt;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_sync <= rx_meta;
    end
  end

  oversample_counter u_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .count  (count)
  );

  assign sample_pt = sample_tick && (count == CNT_W'(MID_SAMPLE));

  // Next-state, datapath and pulse decode; nothing moves without a tick.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    cv_d      = 1'b0;
    fe_d      = 1'b0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    if (sample_tick) begin
      cnt_en = (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (!rx_sync) begin
            state_d   = StStart;
            cnt_clear = 1'b1;
          end
        end
        StStart: begin
          if (sample_pt) begin
            if (!rx_sync) begin
              state_d = StData;
              idx_d   = 3'd0;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StData: begin
          if (sample_pt) begin
            // LSB arrives first, so shifting right leaves it at bit 0.
            shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
            idx_d   = idx_q + 3'd1;
            if (idx_q == IdxLast) begin
              state_d = StStop;
            end
          end
        end
        StStop: begin
          if (sample_pt) begin
            if (rx_sync) begin
              data_d                 = '0;
              data_d[DATA_BITS-1:0]  = shift_q;
              cv_d                   = 1'b1;
              state_d                = StIdle;
            end else begin
              fe_d    = 1'b1;
              state_d = StBreak;
            end
          end
        end
        StBreak: begin
          // Wait for the line to go high so a held-low line cannot retrigger.
          if (rx_sync) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      cv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      cv_q    <= cv_d;
      fe_q    <= fe_d;
    end
  end

  assign data_out      = data_q;
  assign char_valid    = cv_q;
  assign framing_error = fe_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller (8-bit and 5-bit instances).
module tb_uart_rx_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_tick = 1'b0;
  logic       rx8 = 1'b1;
  logic       rx5 = 1'b1;
  logic [7:0] data8, data5;
  logic       cv8, fe8, busy8, cv5, fe5, busy5;

  int errors = 0;
  int checks = 0;
  int cv8_n = 0, fe8_n = 0, cv5_n = 0, fe5_n = 0, overlap_n = 0;
  int div = 0;
  logic [7:0] cv8_prev = 8'h00, cv8_last = 8'h00;

  uart_rx_controller #(.DATA_BITS(8)) dut8 (
    .clk           (clk),
    .rst           (rst),
    .sample_tick   (sample_tick),
    .rx_in         (rx8),
    .data_out      (data8),
    .char_valid    (cv8),
    .framing_error (fe8),
    .busy          (busy8)
  );

  uart_rx_controller #(.DATA_BITS(5)) dut5 (
    .clk           (clk),
    .rst           (rst),
    .sample_tick   (sample_tick),
    .rx_in         (rx5),
    .data_out      (data5),
    .char_valid    (cv5),
    .framing_error (fe5),
    .busy          (busy5)
  );

  always #5 clk = ~clk;

  // One-clk tick every 4 clk, changed on the falling edge.
  always @(negedge clk) begin
    div = (div + 1) % 4;
    sample_tick = (div == 0);
  end

  // Pulse monitor.
  always @(negedge clk) begin
    if (cv8) begin
      cv8_n++;
      cv8_prev = cv8_last;
      cv8_last = data8;
    end
    if (fe8) fe8_n++;
    if (cv5) cv5_n++;
    if (fe5) fe5_n++;
    if ((cv8 && fe8) || (cv5 && fe5)) overlap_n++;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!sample_tick) @(posedge clk);
    end
    #1;
  endtask

  // Start bit plus n data bits on the chosen line; stop level held for stop_ticks.
  task automatic drive_frame(input bit on5, input logic [7:0] d, input int n,
                             input logic stop, input int stop_ticks);
    if (on5) rx5 = 1'b0; else rx8 = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < n; i++) begin
      if (on5) rx5 = d[i]; else rx8 = d[i];
      wait_ticks(16);
    end
    if (on5) rx5 = stop; else rx8 = stop;
    if (stop_ticks > 0) wait_ticks(stop_ticks);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (data8 !== 8'h00) begin errors++; $display("FAIL reset_data8: got %h want 00", data8); end
    checks++; if (cv8 !== 1'b0) begin errors++; $display("FAIL reset_cv8: got %b want 0", cv8); end
    checks++; if (fe8 !== 1'b0) begin errors++; $display("FAIL reset_fe8: got %b want 0", fe8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8: got %b want 0", busy8); end
    checks++; if (data5 !== 8'h00) begin errors++; $display("FAIL reset_data5: got %h want 00", data5); end
    checks++; if (busy5 !== 1'b0) begin errors++; $display("FAIL reset_busy5: got %b want 0", busy5); end
    @(negedge clk);
    rst = 1'b0;
    wait_ticks(4);
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL idle_busy8: got %b want 0", busy8); end
  endtask

  task automatic test_frame_a5();
    int cb = cv8_n, fb = fe8_n;
    drive_frame(1'b0, 8'hA5, 8, 1'b1, 16);
    wait_ticks(4);
    checks++; if (cv8_n - cb !== 1) begin errors++; $display("FAIL a5_cv_count: got %0d want 1", cv8_n - cb); end
    checks++; if (fe8_n - fb !== 0) begin errors++; $display("FAIL a5_fe_count: got %0d want 0", fe8_n - fb); end
    checks++; if (cv8_last !== 8'hA5) begin errors++; $display("FAIL a5_pulse_data: got %h want a5", cv8_last); end
    checks++; if (data8 !== 8'hA5) begin errors++; $display("FAIL a5_data: got %h want a5", data8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL a5_busy: got %b want 0", busy8); end
  endtask

  task automatic test_false_start();
    int cb = cv8_n, fb = fe8_n;
    rx8 = 1'b0;
    wait_ticks(4);
    rx8 = 1'b1;
    wait_ticks(2);
    checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL fs_busy_before: got %b want 1", busy8); end
    wait_ticks(4);
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL fs_busy_after: got %b want 0", busy8); end
    wait_ticks(16);
    checks++; if (cv8_n - cb !== 0) begin errors++; $display("FAIL fs_cv_count: got %0d want 0", cv8_n - cb); end
    checks++; if (fe8_n - fb !== 0) begin errors++; $display("FAIL fs_fe_count: got %0d want 0", fe8_n - fb); end
    checks++; if (data8 !== 8'hA5) begin errors++; $display("FAIL fs_data: got %h want a5", data8); end
  endtask

  task automatic test_break();
    int cb = cv8_n, fb = fe8_n;
    drive_frame(1'b0, 8'h3C, 8, 1'b0, 40);
    checks++; if (fe8_n - fb !== 1) begin errors++; $display("FAIL brk_fe_count: got %0d want 1", fe8_n - fb); end
    checks++; if (cv8_n - cb !== 0) begin errors++; $display("FAIL brk_cv_count: got %0d want 0", cv8_n - cb); end
    checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL brk_busy_held: got %b want 1", busy8); end
    checks++; if (data8 !== 8'hA5) begin errors++; $display("FAIL brk_data: got %h want a5", data8); end
    rx8 = 1'b1;
    wait_ticks(1);
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL brk_release: got %b want 0", busy8); end
    wait_ticks(8);
    checks++; if (fe8_n - fb !== 1) begin errors++; $display("FAIL brk_no_retrigger: got %0d want 1", fe8_n - fb); end
  endtask

  task automatic test_back_to_back();
    int cb = cv8_n;
    drive_frame(1'b0, 8'h00, 8, 1'b1, 16);
    drive_frame(1'b0, 8'hFF, 8, 1'b1, 16);
    wait_ticks(2);
    checks++; if (cv8_n - cb !== 2) begin errors++; $display("FAIL b2b_cv_count: got %0d want 2", cv8_n - cb); end
    checks++; if (cv8_prev !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h want 00", cv8_prev); end
    checks++; if (cv8_last !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h want ff", cv8_last); end
    checks++; if (data8 !== 8'hFF) begin errors++; $display("FAIL b2b_data: got %h want ff", data8); end
  endtask

  task automatic test_reset_mid_frame();
    int cb = cv8_n, fb = fe8_n;
    rx8 = 1'b0;
    wait_ticks(16);
    rx8 = 1'b1; wait_ticks(16);
    rx8 = 1'b0; wait_ticks(16);
    rx8 = 1'b1; wait_ticks(16);
    rx8 = 1'b0; wait_ticks(8);
    @(negedge clk);
    rst = 1'b1;
    rx8 = 1'b1;
    @(negedge clk);
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy8); end
    rst = 1'b0;
    wait_ticks(20);
    checks++; if (cv8_n - cb !== 0) begin errors++; $display("FAIL rmid_cv_count: got %0d want 0", cv8_n - cb); end
    checks++; if (fe8_n - fb !== 0) begin errors++; $display("FAIL rmid_fe_count: got %0d want 0", fe8_n - fb); end
    checks++; if (data8 !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h want 00", data8); end
    drive_frame(1'b0, 8'h81, 8, 1'b1, 16);
    wait_ticks(2);
    checks++; if (cv8_n - cb !== 1) begin errors++; $display("FAIL rmid_next_cv: got %0d want 1", cv8_n - cb); end
    checks++; if (data8 !== 8'h81) begin errors++; $display("FAIL rmid_next_data: got %h want 81", data8); end
  endtask

  task automatic test_five_bit();
    int cb = cv5_n, fb = fe5_n;
    drive_frame(1'b1, 8'h13, 5, 1'b1, 4);
    checks++; if (cv5_n - cb !== 0) begin errors++; $display("FAIL b5_early_cv: got %0d want 0", cv5_n - cb); end
    wait_ticks(12);
    checks++; if (cv5_n - cb !== 1) begin errors++; $display("FAIL b5_cv_count: got %0d want 1", cv5_n - cb); end
    checks++; if (fe5_n - fb !== 0) begin errors++; $display("FAIL b5_fe_count: got %0d want 0", fe5_n - fb); end
    checks++; if (data5 !== 8'h13) begin errors++; $display("FAIL b5_data: got %h want 13", data5); end
    checks++; if (busy5 !== 1'b0) begin errors++; $display("FAIL b5_busy: got %b want 0", busy5); end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_false_start();
    test_break();
    test_back_to_back();
    test_reset_mid_frame();
    test_five_bit();
    checks++; if (overlap_n !== 0) begin errors++; $display("FAIL pulse_overlap: got %0d want 0", overlap_n); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_controller.md
UART_RX_CONTROLLER -- requirements
Module: uart_rx_controller

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, giving data bits per frame; legal range 5..8.
REQ-002 The block SHALL have input clk, 1 bit, the system clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have input rst, 1 bit; reset is rst, synchronous, active-high.
REQ-004 The block SHALL have input sample_tick, 1 bit, a one-clk pulse at 16x the baud rate; state advances only on cycles where it is high.
REQ-005 The block SHALL have input rx_in, 1 bit, the asynchronous serial line; it idles high.
REQ-006 The block SHALL have output data_out, 8 bits, the last correctly framed character, right-aligned, upper bits zero when DATA_BITS<8.
REQ-007 The block SHALL have output char_valid, 1 bit, a one-clk pulse when data_out has been updated.
REQ-008 The block SHALL have output framing_error, 1 bit, a one-clk pulse when the stop bit is sampled low.
REQ-009 The block SHALL have output busy, 1 bit, high in every state except IDLE.

Function
REQ-010 rx_in SHALL pass through a 2-flop synchronizer (rx_sync) before use; all decisions use rx_sync.
REQ-011 The block SHALL have states IDLE, START, DATA, STOP and BREAK.
REQ-012 A 4-bit sample count SHALL be cleared to 0 on start detection and SHALL increment mod 16 on every tick outside IDLE.
REQ-013 A "sample point" SHALL be a tick on which the count equals 7 before it increments.
REQ-014 IDLE: a tick with rx_sync=0 SHALL enter START and clear the count.
REQ-015 START sample point: rx_sync=0 SHALL enter DATA with bit index 0; rx_sync=1 is a false start and SHALL return to IDLE with no output pulse.
REQ-016 DATA sample point: rx_sync SHALL shift into the shift-register MSB (LSB-first framing) and the bit index SHALL increment; the sample with index DATA_BITS-1 SHALL enter STOP.
REQ-017 STOP sample point, rx_sync=1: data_out SHALL load the shift register, right-justified, and char_valid SHALL pulse; both take effect one cycle after the sample point. The state SHALL then be IDLE.
REQ-018 STOP sample point, rx_sync=0: framing_error SHALL pulse one cycle after the sample point, data_out SHALL be unchanged, and the state SHALL enter BREAK.
REQ-019 BREAK: a tick with rx_sync=1 SHALL return to IDLE; this prevents a held-low line from retriggering.
REQ-020 Cycles without a tick SHALL hold all state, the count, the index and the shift register; the output pulses SHALL still clear after one cycle.
REQ-021 A start edge on the tick right after returning to IDLE SHALL be accepted; back-to-back frames have no gap requirement.
REQ-022 char_valid and framing_error SHALL never be high in the same cycle.

Reset
REQ-023 On rst the block SHALL set: state IDLE, count 0, bit index 0, shift register 0, data_out 0, char_valid 0, framing_error 0, busy 0, and both synchronizer flops 1.
REQ-024 rst SHALL override sample_tick; rst asserted mid-frame SHALL abandon the frame with no pulse, and busy SHALL be low the following cycle.

Structure
REQ-025 The state enum, OVERSAMPLE=16 and MID_SAMPLE=7 SHALL live in shared package uart_rx_pkg.
REQ-026 The mod-16 sample count SHALL be a sub-module oversample_counter with clear, enable and a 4-bit count output; the FSM, synchronizer and shift register stay in uart_rx_controller.

Verification (sample_tick every 4 clk, bit period 16 ticks)
REQ-027 Send frame 0xA5 (0, 1,0,1,0,0,1,0,1, 1) -> data_out=0xA5 and a single char_valid pulse; framing_error stays 0.
REQ-028 Drive rx_in low for 4 ticks, then high -> busy drops after the START sample point; no char_valid, no framing_error, data_out unchanged.
REQ-029 Send 0x3C with stop bit 0 and hold the line low 40 ticks -> one framing_error pulse and busy held high (BREAK); busy low one tick after the line returns high; data_out unchanged.
REQ-030 Send 0x00 and 0xFF back-to-back with no idle gap -> two char_valid pulses, with data_out 0x00 then 0xFF.
REQ-031 Assert rst during data bit 3 of 0x55 -> busy=0 the next cycle, no pulses; a following frame 0x81 is received correctly.
REQ-032 With DATA_BITS=5, send 0x13 -> data_out=0x13, char_valid pulses, stop bit sampled at the 7th bit period.
